instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
- Multi-cycle fetch/decode/execute controller for the 8-bit CPU.
- Sequences the program counter (`pc`) by driving its `enable`, `load` and `load_value` inputs.
- Also sequences the instruction register load, the memory request handshake and the ALU/register-file write strobes.
- Sits between the memory port, the IR and the datapath; it holds no architectural data except the latched branch target.

Parameters:
- `OPC_W`, 4, opcode width taken from `ir_opcode`.
- `ADDR_W`, 8, width of the PC and of `pc_load_value`.

Ports:
- `clk`  in  1  system clock, all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ir_opcode`  in  `OPC_W`  opcode field of the IR (valid from DECODE onward).
- `zero_flag`  in  1  ALU zero flag, sampled in BRANCH.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `mem_rdata`  in  8  memory read data.
- `mem_req`  out  1  memory access request.
- `mem_we`  out  1  write qualifier for `mem_req`.
- `addr_sel`  out  1  0 = address from PC, 1 = address from data pointer register.
- `pc_enable`  out  1  one-cycle PC increment pulse.
- `pc_load`  out  1  one-cycle PC load pulse.
- `pc_load_value`  out  `ADDR_W`  branch target, valid while `pc_load` = 1.
- `ir_load`  out  1  IR capture strobe.
- `alu_en`  out  1  ALU execute strobe.
- `reg_we`  out  1  register-file write strobe.
- `halted`  out  1  core stopped.

Behaviour:
- Reset (`reset` = 1 at a posedge, any state):
  - state = FETCH and target = 8'h00.
  - All strobes are 0 and `halted` = 0.
  - Reset aborts any in-flight memory access; `mem_req` drops on the next cycle.
- Outputs are Moore-decoded from state, except where noted for completion-qualified strobes.
- Memory handshake:
  - `mem_req` stays high until a posedge where `mem_ready` = 1; that cycle completes the access.
  - `mem_ready` is ignored while `mem_req` = 0.
  - `mem_we` and `addr_sel` are stable for the whole request.
- FETCH: `mem_req` = 1, `addr_sel` = 0.
  - On completion: `ir_load` = 1 and `pc_enable` = 1 in the same cycle (combinationally qualified by `mem_ready`); next state DECODE.
  - Minimum fetch is 1 cycle; each wait cycle adds 1.
- DECODE: one cycle, no strobes. Next state by opcode:
  - 0x0 NOP → FETCH.
  - 0x1–0x7 ALU → EXEC.
  - 0x8 LOAD, 0x9 STORE → MEM.
  - 0xA JMP, 0xB BZ → OPND.
  - 0xF HALT → HALT.
  - 0xC–0xE reserved: treated as NOP.
- EXEC: `alu_en` = 1 and `reg_we` = 1 for one cycle → FETCH.
- MEM: `mem_req` = 1, `addr_sel` = 1, `mem_we` = (opcode == 0x9).
  - On completion: `reg_we` = 1 if LOAD; next state FETCH.
- OPND: `mem_req` = 1, `addr_sel` = 0.
  - On completion: target ← `mem_rdata` and `pc_enable` = 1; next state BRANCH.
- BRANCH: one cycle.
  - `pc_load` = 1 if JMP, or if BZ and `zero_flag` = 1.
  - `pc_load_value` = target; next state FETCH.
  - A not-taken BZ falls through with the PC already past the operand.
- HALT: `halted` = 1 and no strobes; remains until `reset`.
- Invariants:
  - `pc_enable` and `pc_load` are never asserted together.
  - `ir_load` is asserted only in FETCH.
- Instruction latencies with zero wait states:
  - NOP: 2 cycles.
  - ALU: 3 cycles.
  - LOAD/STORE: 3 cycles.
  - JMP/BZ: 4 cycles.
- PC wrap (0xFF→0x00) is owned by the PC; the sequencer does not special-case it.

Optional Feature:
- Macro: `INSTR_SEQUENCER_SINGLE_STEP_EN`.
- Defined:
  - Adds input `step` (1 bit) and output `step_wait` (1 bit).
  - Every transition into FETCH goes instead to STEP_WAIT, with `step_wait` = 1 and no strobes.
  - A `step` = 1 sampled at a posedge moves STEP_WAIT → FETCH.
  - The first FETCH after reset also waits.
  - HALT overrides stepping.
- Undefined: neither port exists, the STEP_WAIT state does not exist, and behaviour is exactly as above.

Decomposition:
- Shared package `cpu_pkg`:
  - State enum: FETCH, DECODE, EXEC, MEM, OPND, BRANCH, HALT, STEP_WAIT (3-bit encoding).
  - Opcode constants: `OP_NOP`, `OP_LOAD`, `OP_STORE`, `OP_JMP`, `OP_BZ`, `OP_HALT`, and the ALU range bounds.
- Sub-module `seq_decode`: combinational opcode→class decoder (`is_alu`, `is_mem`, `is_store`, `is_branch`, `is_cond`, `is_halt`). The FSM and the target register stay in the top module.

Test Plan:
- Reset, then NOP stream with `mem_ready` tied 1 → `ir_load`/`pc_enable` pulse every 2 cycles; a `pc` instance counts 0,1,2,3.
- JMP with operand byte 0x0A, zero waits → `pc` = 2 after OPND, then `pc_load` = 1 with `pc_load_value` = 0x0A; next fetch address is 10.
- BZ 0x20 with `zero_flag` = 0, then BZ 0x20 with `zero_flag` = 1 → first: no `pc_load`, PC = 2; second: PC = 0x20.
- STORE with `mem_ready` held low 3 cycles → `mem_req` = 1, `mem_we` = 1, `addr_sel` = 1 held for 4 cycles; `reg_we` never asserts.
- HALT opcode → `halted` = 1 and all strobes 0 for 20 cycles; `reset` pulse → state FETCH and `halted` = 0 next cycle.
- `reset` asserted mid-FETCH wait and mid-OPND → all outputs 0 after the edge, FETCH resumes; with `INSTR_SEQUENCER_SINGLE_STEP_EN`, no fetch occurs until `step` = 1.

Source files
------------

// File: rtl/instr_sequencer_pkg.sv
// Shared CPU definitions: sequencer state encoding and opcode map.
// Latency: n/a (types and constants only).
// Backpressure: n/a. INSTR_SEQUENCER_SINGLE_STEP_EN adds the STEP_WAIT state.
package cpu_pkg;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXEC      = 3'd2,
    MEM       = 3'd3,
    OPND      = 3'd4,
    BRANCH    = 3'd5,
    HALT      = 3'd6
`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
    ,
    STEP_WAIT = 3'd7
`endif
  } state_t;

  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_ALU_LO = 4'h1;
  localparam logic [3:0] OP_ALU_HI = 4'h7;
  localparam logic [3:0] OP_LOAD   = 4'h8;
  localparam logic [3:0] OP_STORE  = 4'h9;
  localparam logic [3:0] OP_JMP    = 4'hA;
  localparam logic [3:0] OP_BZ     = 4'hB;
  localparam logic [3:0] OP_HALT   = 4'hF;

endpackage

// File: rtl/instr_sequencer_if.sv
// Bundle between the sequencer and memory port / IR / PC / datapath.
// Latency: n/a (wires only).
// Backpressure: memory stalls via mem_ready; INSTR_SEQUENCER_SINGLE_STEP_EN adds step/step_wait.
interface instr_sequencer_if #(
  parameter int OPC_W  = 4,
  parameter int ADDR_W = 8
) ();
  logic [OPC_W-1:0]  ir_opcode;
  logic              zero_flag;
  logic              mem_ready;
  logic [7:0]        mem_rdata;
  logic              mem_req;
  logic              mem_we;
  logic              addr_sel;
  logic              pc_enable;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_load_value;
  logic              ir_load;
  logic              alu_en;
  logic              reg_we;
  logic              halted;
`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
  logic              step;
  logic              step_wait;

  modport master (
    input  ir_opcode, zero_flag, mem_ready, mem_rdata, step,
    output mem_req, mem_we, addr_sel, pc_enable, pc_load, pc_load_value,
           ir_load, alu_en, reg_we, halted, step_wait
  );
  modport slave (
    output ir_opcode, zero_flag, mem_ready, mem_rdata, step,
    input  mem_req, mem_we, addr_sel, pc_enable, pc_load, pc_load_value,
           ir_load, alu_en, reg_we, halted, step_wait
  );
`else
  modport master (
    input  ir_opcode, zero_flag, mem_ready, mem_rdata,
    output mem_req, mem_we, addr_sel, pc_enable, pc_load, pc_load_value,
           ir_load, alu_en, reg_we, halted
  );
  modport slave (
    output ir_opcode, zero_flag, mem_ready, mem_rdata,
    input  mem_req, mem_we, addr_sel, pc_enable, pc_load, pc_load_value,
           ir_load, alu_en, reg_we, halted
  );
`endif
endinterface

// File: rtl/instr_sequencer_decode.sv
// Opcode to instruction-class decoder; reserved opcodes fall out as NOP.
// Latency: combinational.
// Backpressure: none.
module seq_decode
  import cpu_pkg::*;
#(
  parameter int OPC_W = 4
) (
  input  logic [OPC_W-1:0] i_opcode,
  output logic             o_is_alu,
  output logic             o_is_mem,
  output logic             o_is_store,
  output logic             o_is_branch,
  output logic             o_is_cond,
  output logic             o_is_halt
);

  assign o_is_alu    = (i_opcode >= OPC_W'(OP_ALU_LO)) && (i_opcode <= OPC_W'(OP_ALU_HI));
  assign o_is_store  = (i_opcode == OPC_W'(OP_STORE));
  assign o_is_mem    = (i_opcode == OPC_W'(OP_LOAD)) || o_is_store;
  assign o_is_cond   = (i_opcode == OPC_W'(OP_BZ));
  assign o_is_branch = (i_opcode == OPC_W'(OP_JMP)) || o_is_cond;
  assign o_is_halt   = (i_opcode == OPC_W'(OP_HALT));

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute sequencer driving PC, IR, memory handshake and datapath strobes.
// Latency: NOP 2, ALU 3, LOAD/STORE 3, JMP/BZ 4 cycles plus one per memory wait cycle.
// Backpressure: holds mem_req until mem_ready; INSTR_SEQUENCER_SINGLE_STEP_EN gates each fetch on step.
module instr_sequencer
  import cpu_pkg::*;
#(
  parameter int OPC_W  = 4,
  parameter int ADDR_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  instr_sequencer_if.master  bus
);

`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
  localparam state_t ST_RESUME = STEP_WAIT;
`else
  localparam state_t ST_RESUME = FETCH;
`endif

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_target;
  logic              r_mem_req;
  logic              r_mem_we;
  logic              r_addr_sel;
  logic              r_alu_en;
  logic              r_halted;
  logic              w_done;
  logic              w_is_alu;
  logic              w_is_mem;
  logic              w_is_store;
  logic              w_is_branch;
  logic              w_is_cond;
  logic              w_is_halt;

  seq_decode #(.OPC_W(OPC_W)) u_decode (
    .i_opcode    (bus.ir_opcode),
    .o_is_alu    (w_is_alu),
    .o_is_mem    (w_is_mem),
    .o_is_store  (w_is_store),
    .o_is_branch (w_is_branch),
    .o_is_cond   (w_is_cond),
    .o_is_halt   (w_is_halt)
  );

  // A memory access completes only when we are actually requesting.
  assign w_done = r_mem_req & bus.mem_ready;

  // Next-state selection; every return to FETCH goes through ST_RESUME.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FETCH:  if (w_done) w_state_nxt = DECODE;
      DECODE: begin
        if (w_is_halt)        w_state_nxt = HALT;
        else if (w_is_alu)    w_state_nxt = EXEC;
        else if (w_is_mem)    w_state_nxt = MEM;
        else if (w_is_branch) w_state_nxt = OPND;
        else                  w_state_nxt = ST_RESUME;
      end
      EXEC:   w_state_nxt = ST_RESUME;
      MEM:    if (w_done) w_state_nxt = ST_RESUME;
      OPND:   if (w_done) w_state_nxt = BRANCH;
      BRANCH: w_state_nxt = ST_RESUME;
      HALT:   w_state_nxt = HALT;
`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
      STEP_WAIT: if (bus.step) w_state_nxt = FETCH;
`endif
      default: w_state_nxt = ST_RESUME;
    endcase
  end

`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
  logic r_step_wait;

  // Step-wait flag tracks the state; reset parks the core before its first fetch.
  always_ff @(posedge clk) begin
    if (reset) r_step_wait <= 1'b1;
    else       r_step_wait <= (w_state_nxt == STEP_WAIT);
  end

  assign bus.step_wait = r_step_wait;
`endif

  // State, branch target and Moore outputs registered from the next state.
  // Reset clears mem_req so an in-flight access is abandoned for one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
      r_state    <= STEP_WAIT;
`else
      r_state    <= FETCH;
`endif
      r_target   <= '0;
      r_mem_req  <= 1'b0;
      r_mem_we   <= 1'b0;
      r_addr_sel <= 1'b0;
      r_alu_en   <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      if ((r_state == OPND) && w_done) r_target <= ADDR_W'(bus.mem_rdata);
      r_mem_req  <= (w_state_nxt == FETCH) || (w_state_nxt == MEM) || (w_state_nxt == OPND);
      r_addr_sel <= (w_state_nxt == MEM);
      r_mem_we   <= (w_state_nxt == MEM) && w_is_store;
      r_alu_en   <= (w_state_nxt == EXEC);
      r_halted   <= (w_state_nxt == HALT);
    end
  end

  assign bus.mem_req       = r_mem_req;
  assign bus.mem_we        = r_mem_we;
  assign bus.addr_sel      = r_addr_sel;
  assign bus.alu_en        = r_alu_en;
  assign bus.halted        = r_halted;
  assign bus.pc_load_value = r_target;
  // Completion-qualified strobes: they fire in the cycle mem_ready closes the access.
  assign bus.ir_load       = (r_state == FETCH) & w_done;
  assign bus.pc_enable     = ((r_state == FETCH) | (r_state == OPND)) & w_done;
  assign bus.reg_we        = r_alu_en | ((r_state == MEM) & w_done & ~w_is_store);
  // Branch decision uses the zero flag as it stands during BRANCH.
  assign bus.pc_load       = (r_state == BRANCH) & w_is_branch & (~w_is_cond | bus.zero_flag);

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer with a PC/IR/memory model and fetch/branch scoreboards.
// Latency: n/a.
// Backpressure: mem_ready driven from the bench to insert wait states.
module tb_instr_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       rdy   = 1'b1;
  logic       zero  = 1'b0;
  logic [7:0] prog [256];
  logic [7:0] pc;
  logic [7:0] ir;
  int         total = 0;
  int         bad   = 0;
  logic [7:0] fetch_q [$];
  logic [7:0] load_q  [$];
  bit         mon_on = 1'b0;

  instr_sequencer_if #(.OPC_W(4), .ADDR_W(8)) bus ();

  instr_sequencer #(.OPC_W(4), .ADDR_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.mem_ready = rdy;
  assign bus.zero_flag = zero;
  assign bus.ir_opcode = ir[7:4];
  assign bus.mem_rdata = bus.addr_sel ? 8'h5A : prog[pc];

`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
  logic step_in = 1'b0;
  assign bus.step = step_in;
`endif

  // PC and IR models owned by the datapath side.
  always @(posedge clk) begin
    if (reset) begin
      pc <= 8'h00;
      ir <= 8'h00;
    end else begin
      if (bus.ir_load) ir <= bus.mem_rdata;
      if (bus.pc_load)        pc <= bus.pc_load_value;
      else if (bus.pc_enable) pc <= pc + 8'd1;
    end
  end

  // Scoreboard: every fetch and every PC load is popped against its expectation.
  always @(negedge clk) begin
    logic [7:0] e;
    #2;
    if (mon_on) begin
      if (bus.ir_load) begin
        total++;
        if (fetch_q.size() == 0) begin
          bad++;
          $display("FAIL fetch_unexpected: fetch at pc=%0h, required none", pc);
        end else begin
          e = fetch_q.pop_front();
          if (pc !== e) begin
            bad++;
            $display("FAIL fetch_addr: got %0h, required %0h", pc, e);
          end
        end
      end
      if (bus.pc_load) begin
        total++;
        if (load_q.size() == 0) begin
          bad++;
          $display("FAIL load_unexpected: pc_load value=%0h, required none", bus.pc_load_value);
        end else begin
          e = load_q.pop_front();
          if (bus.pc_load_value !== e) begin
            bad++;
            $display("FAIL load_value: got %0h, required %0h", bus.pc_load_value, e);
          end
        end
      end
      total++;
      if ((bus.pc_enable & bus.pc_load) !== 1'b0) begin
        bad++;
        $display("FAIL pc_inc_and_load: got %b, required 0", bus.pc_enable & bus.pc_load);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_prog();
    foreach (prog[i]) prog[i] = 8'h00;
  endtask

  // Leaves reset asserted across two edges; returns at a negedge with reset still 1.
  task automatic hold_reset();
    reset = 1'b1; rdy = 1'b1; zero = 1'b0; mon_on = 1'b0;
    fetch_q.delete(); load_q.delete();
    tick(); tick();
  endtask

  task automatic release_reset();
    reset = 1'b0;
    mon_on = 1'b1;
  endtask

  task automatic finish_mon(input string name);
    #3;
    mon_on = 1'b0;
    total++;
    if (fetch_q.size() != 0 || load_q.size() != 0) begin
      bad++;
      $display("FAIL %s_pending: got fetch=%0d load=%0d left, required 0 0", name, fetch_q.size(), load_q.size());
    end
  endtask

  task automatic test_reset();
    clear_prog();
    hold_reset();
    #1;
    total++;
    if ({bus.mem_req, bus.mem_we, bus.addr_sel, bus.ir_load, bus.pc_enable, bus.pc_load,
         bus.alu_en, bus.reg_we, bus.halted} !== 9'b0) begin
      bad++;
      $display("FAIL reset_outputs: got %b, required 0", {bus.mem_req, bus.mem_we, bus.addr_sel,
               bus.ir_load, bus.pc_enable, bus.pc_load, bus.alu_en, bus.reg_we, bus.halted});
    end
    total++;
    if (bus.pc_load_value !== 8'h00) begin
      bad++;
      $display("FAIL reset_target: got %0h, required 0", bus.pc_load_value);
    end
  endtask

  task automatic test_nop();
    clear_prog();
    hold_reset();
    fetch_q.push_back(8'h00); fetch_q.push_back(8'h01);
    fetch_q.push_back(8'h02); fetch_q.push_back(8'h03);
    release_reset();
    for (int k = 1; k <= 7; k++) begin
      tick(); #1;
      total++;
      if (bus.ir_load !== ((k % 2) == 1)) begin
        bad++;
        $display("FAIL nop_ir_load[%0d]: got %b, required %b", k, bus.ir_load, (k % 2) == 1);
      end
    end
    finish_mon("nop");
  endtask

  task automatic test_jmp();
    clear_prog();
    prog[0] = 8'hA0; prog[1] = 8'h0A;
    hold_reset();
    fetch_q.push_back(8'h00); fetch_q.push_back(8'h0A);
    load_q.push_back(8'h0A);
    release_reset();
    for (int k = 1; k <= 5; k++) begin
      tick(); #1;
      if (k == 3) begin
        total++;
        if ({bus.mem_req, bus.addr_sel, bus.pc_enable} !== 3'b101) begin
          bad++;
          $display("FAIL jmp_opnd: got %b, required 101", {bus.mem_req, bus.addr_sel, bus.pc_enable});
        end
      end
      if (k == 4) begin
        total++;
        if (pc !== 8'h02 || bus.pc_load !== 1'b1) begin
          bad++;
          $display("FAIL jmp_branch: got pc=%0h load=%b, required pc=2 load=1", pc, bus.pc_load);
        end
      end
    end
    finish_mon("jmp");
  endtask

  task automatic test_bz();
    clear_prog();
    prog[0] = 8'hB0; prog[1] = 8'h20; prog[2] = 8'hB0; prog[3] = 8'h20;
    hold_reset();
    fetch_q.push_back(8'h00); fetch_q.push_back(8'h02); fetch_q.push_back(8'h20);
    load_q.push_back(8'h20);
    release_reset();
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 5) zero = 1'b1;
      #1;
      if (k == 4) begin
        total++;
        if (pc !== 8'h02 || bus.pc_load !== 1'b0) begin
          bad++;
          $display("FAIL bz_not_taken: got pc=%0h load=%b, required pc=2 load=0", pc, bus.pc_load);
        end
      end
      if (k == 8) begin
        total++;
        if (bus.pc_load !== 1'b1) begin
          bad++;
          $display("FAIL bz_taken: got load=%b, required 1", bus.pc_load);
        end
      end
    end
    finish_mon("bz");
  endtask

  task automatic test_store_wait();
    clear_prog();
    prog[0] = 8'h90;
    hold_reset();
    fetch_q.push_back(8'h00); fetch_q.push_back(8'h01);
    release_reset();
    for (int k = 1; k <= 7; k++) begin
      tick();
      rdy = (k >= 3 && k <= 5) ? 1'b0 : 1'b1;
      #1;
      if (k >= 3 && k <= 6) begin
        total++;
        if ({bus.mem_req, bus.mem_we, bus.addr_sel} !== 3'b111) begin
          bad++;
          $display("FAIL store_hold[%0d]: got %b, required 111", k, {bus.mem_req, bus.mem_we, bus.addr_sel});
        end
      end
      total++;
      if (bus.reg_we !== 1'b0) begin
        bad++;
        $display("FAIL store_reg_we[%0d]: got %b, required 0", k, bus.reg_we);
      end
    end
    finish_mon("store");
  endtask

  task automatic test_alu_load();
    clear_prog();
    prog[0] = 8'h10; prog[1] = 8'h80;
    hold_reset();
    fetch_q.push_back(8'h00); fetch_q.push_back(8'h01); fetch_q.push_back(8'h02);
    release_reset();
    for (int k = 1; k <= 7; k++) begin
      tick(); #1;
      if (k == 3) begin
        total++;
        if ({bus.alu_en, bus.reg_we, bus.mem_req} !== 3'b110) begin
          bad++;
          $display("FAIL alu_exec: got %b, required 110", {bus.alu_en, bus.reg_we, bus.mem_req});
        end
      end
      if (k == 6) begin
        total++;
        if ({bus.mem_req, bus.addr_sel, bus.mem_we, bus.reg_we, bus.alu_en} !== 5'b11010) begin
          bad++;
          $display("FAIL load_mem: got %b, required 11010",
                   {bus.mem_req, bus.addr_sel, bus.mem_we, bus.reg_we, bus.alu_en});
        end
      end
    end
    finish_mon("alu_load");
  endtask

  task automatic test_halt();
    clear_prog();
    prog[0] = 8'hF0;
    hold_reset();
    fetch_q.push_back(8'h00);
    release_reset();
    for (int k = 1; k <= 22; k++) begin
      tick(); #1;
      if (k >= 3) begin
        total++;
        if ({bus.halted, bus.mem_req, bus.ir_load, bus.pc_enable, bus.pc_load,
             bus.alu_en, bus.reg_we, bus.mem_we} !== 8'b1000_0000) begin
          bad++;
          $display("FAIL halt_hold[%0d]: got %b, required 10000000", k, {bus.halted, bus.mem_req,
                   bus.ir_load, bus.pc_enable, bus.pc_load, bus.alu_en, bus.reg_we, bus.mem_we});
        end
      end
    end
    finish_mon("halt");
    reset = 1'b1;
    tick(); #1;
    total++;
    if ({bus.halted, bus.mem_req} !== 2'b00) begin
      bad++;
      $display("FAIL halt_reset: got %b, required 00", {bus.halted, bus.mem_req});
    end
    fetch_q.push_back(8'h00);
    release_reset();
    tick(); #1;
    total++;
    if (bus.ir_load !== 1'b1) begin
      bad++;
      $display("FAIL halt_refetch: got %b, required 1", bus.ir_load);
    end
    finish_mon("halt_refetch");
  endtask

  task automatic test_reset_mid();
    clear_prog();
    hold_reset();
    rdy = 1'b0;
    fetch_q.push_back(8'h00);
    release_reset();
    tick(); tick(); #1;
    total++;
    if ({bus.mem_req, bus.ir_load} !== 2'b10) begin
      bad++;
      $display("FAIL fetch_wait: got %b, required 10", {bus.mem_req, bus.ir_load});
    end
    reset = 1'b1;
    tick(); #1;
    total++;
    if ({bus.mem_req, bus.ir_load, bus.pc_enable} !== 3'b000) begin
      bad++;
      $display("FAIL fetch_abort: got %b, required 000", {bus.mem_req, bus.ir_load, bus.pc_enable});
    end
    reset = 1'b0; rdy = 1'b1;
    tick(); #1;
    finish_mon("fetch_abort");

    prog[0] = 8'hA0; prog[1] = 8'h0A;
    hold_reset();
    fetch_q.push_back(8'h00); fetch_q.push_back(8'h00);
    release_reset();
    tick(); tick(); tick();
    rdy = 1'b0;
    #1;
    total++;
    if ({bus.mem_req, bus.pc_enable} !== 2'b10) begin
      bad++;
      $display("FAIL opnd_wait: got %b, required 10", {bus.mem_req, bus.pc_enable});
    end
    reset = 1'b1;
    tick(); #1;
    total++;
    if ({bus.mem_req, bus.pc_enable, bus.pc_load, pc} !== 11'b0) begin
      bad++;
      $display("FAIL opnd_abort: got %b pc=%0h, required 0 pc=0", {bus.mem_req, bus.pc_enable, bus.pc_load}, pc);
    end
    reset = 1'b0; rdy = 1'b1;
    tick(); #1;
    finish_mon("opnd_abort");
  endtask

`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
  task automatic test_step();
    clear_prog();
    step_in = 1'b0;
    hold_reset();
    fetch_q.push_back(8'h00);
    release_reset();
    for (int k = 1; k <= 9; k++) begin
      tick();
      step_in = (k == 6) ? 1'b1 : 1'b0;
      #1;
      if (k <= 6 || k == 9) begin
        total++;
        if ({bus.step_wait, bus.mem_req} !== 2'b10) begin
          bad++;
          $display("FAIL step_wait[%0d]: got %b, required 10", k, {bus.step_wait, bus.mem_req});
        end
      end
      if (k == 7) begin
        total++;
        if (bus.ir_load !== 1'b1) begin
          bad++;
          $display("FAIL step_fetch: got %b, required 1", bus.ir_load);
        end
      end
    end
    finish_mon("step");
  endtask
`endif

  initial begin
    clear_prog();
    test_reset();
`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
    test_step();
`else
    test_nop();
    test_jmp();
    test_bz();
    test_store_wait();
    test_alu_load();
    test_halt();
    test_reset_mid();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
